fpu_arbiter: RTL and testbench
==============================

// Module: fpu_arbiter
// PURPOSE
//  Round-robin scheduler sharing one free-running fpu adder among N_REQ requesters.
//  - Grants one request at a time and latches its operand pair.
//  - Holds the operands on the FPU inputs until the result and status are settled.
//  - Returns the sampled result, status and requester id as a one-cycle response.
//  - Sits between the client blocks and the single fpu instance; clocked by clock100KHz.
// PARAMETERS
//  N_REQ       4    number of requesters (2..8)
//  HOLD_CYCLES 256  cycles operands are held before sampling; must be >= 204
//  ID_W        $clog2(N_REQ)  width of rsp_id (derived, not overridable)
// PORTS
//  clock100KHz  in   1         system clock
//  reset        in   1         synchronous, active-low reset
//  req_valid    in   N_REQ     request pending, one bit per requester
//  req_op_a     in   32*N_REQ  operand A; requester i uses bits [32*i+31:32*i]
//  req_op_b     in   32*N_REQ  operand B; same packing as req_op_a
//  req_ready    out  N_REQ     grant strobe; at most one bit high (combinational)
//  rsp_valid    out  1         one-cycle response pulse
//  rsp_id       out  ID_W      index of the requester that owns the response
//  rsp_data     out  32        result word {sign, exp[5:0], mant[24:0]}
//  rsp_status   out  4         one-hot: 0001 EXACT, 0010 INEXACT, 0100 OVERFLOW, 1000 UNDERFLOW
//  busy         out  1         high from grant until the response pulse ends
//  fpu_op_a     out  32        to fpu op_A_in
//  fpu_op_b     out  32        to fpu op_B_in
//  fpu_data_in  in   32        from fpu data_out
//  fpu_status_in in  4         from fpu status_out
// BEHAVIOUR
//  Reset (reset==0 at a clock edge):
//  - state=IDLE, RR pointer=0.
//  - rsp_valid, rsp_id, rsp_data, rsp_status, busy, fpu_op_a and fpu_op_b all go to 0.
//  - Reset mid-operation aborts the transaction: no response is issued and the request is lost.
//  FPU timing:
//  - The FPU has no handshake. One FPU pass is at most 68 cycles.
//  - status_out lags data_out by one pass.
//  - Sample only after operands are stable for 3 full passes, i.e. HOLD_CYCLES >= 204.
//  States:
//  - IDLE: req_ready[i]=1 only for the winner i, the first req_valid bit at or after the RR pointer (cyclic search).
//  - IDLE, on grant at edge T: latch the op pair and id; pointer=(i+1) mod N_REQ; busy=1; go to WAIT.
//  - IDLE with no valid request: stay in IDLE, all req_ready bits 0.
//  - WAIT: cycles T+1..T+HOLD_CYCLES. fpu_op_a/b drive the latched operands from T+1. Counter runs 0..HOLD_CYCLES-1.
//  - WAIT, at the last cycle's edge: rsp_data<=fpu_data_in, rsp_status<=fpu_status_in, rsp_id<=latched id; go to RESPOND.
//  - RESPOND: rsp_valid=1 for exactly cycle T+HOLD_CYCLES+1; busy drops at the end; go to IDLE.
//  - Earliest next grant is at edge T+HOLD_CYCLES+2.
//  Outputs and request rules:
//  - rsp_data/rsp_status/rsp_id hold their value until the next response.
//  - fpu_op_a/b keep the last operands while idle.
//  - req_valid changes during WAIT are ignored; a request stays pending until req_ready is seen.
//  - There is no response backpressure: the client must take the rsp_valid pulse.
//  - Simultaneous requests: exactly one grant per IDLE visit; the others wait.
//  - RR guarantee: each valid requester is served within N_REQ transactions.
//  - Unused state encodings return to IDLE.
// TESTING
//  1. Only req 0 valid, A=B=32'h40000000 -> grant at T; rsp_valid at T+257; rsp_id=0; rsp_data=32'h42000000; rsp_status=4'b0001.
//  2. Req 2 valid, A=32'h40000000, B=32'hC0000000 -> rsp_id=2; rsp_data=32'h0; rsp_status=4'b0001.
//  3. All 4 req_valid held high from reset -> grant order 0,1,2,3,0; grants exactly 258 cycles apart.
//  4. Req 1 and req 3 valid, pointer=2 -> req 3 granted first, then req 1.
//  5. reset=0 at T+100 of a transaction -> no rsp_valid; all outputs 0 on the next cycle; pointer=0.
//  6. req_valid[1] toggled during WAIT -> no extra grant; busy stays high and req_ready stays 0 until RESPOND is done.

Source files
------------

// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_arbiter
// Purpose  : Round-robin scheduler sharing one free-running FPU adder among
//            N_REQ requesters; holds operands until the FPU output settles.
// Revision : 1.0  initial release
// ============================================================================
module fpu_arbiter #(
    parameter int  N_REQ       = 4,
    parameter int  HOLD_CYCLES = 256,
    localparam int ID_W        = $clog2(N_REQ)
) (
    input  logic                 clock100KHz,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_op_a,
    input  logic [32*N_REQ-1:0]  req_op_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_data,
    output logic [3:0]           rsp_status,
    output logic                 busy,
    output logic [31:0]          fpu_op_a,
    output logic [31:0]          fpu_op_b,
    input  logic [31:0]          fpu_data_in,
    input  logic [3:0]           fpu_status_in
);

    localparam int c_CNT_W = $clog2(HOLD_CYCLES);

    typedef enum logic [1:0] {
        c_IDLE    = 2'b00,
        c_WAIT    = 2'b01,
        c_RESPOND = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [ID_W-1:0]     w_win_id;
    logic                w_win_found;
    logic [ID_W:0]       w_sum;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                w_last;
    logic                w_grant;
    logic [N_REQ-1:0]    w_ready;
    logic                r_busy;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [31:0]         r_rsp_data;
    logic [3:0]          r_rsp_status;
    logic [31:0]         r_op_a;
    logic [31:0]         r_op_b;

    // Cyclic search for the first pending request at or after the pointer.
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        w_sum       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(N_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(N_REQ);
            end
            if (!w_win_found && req_valid[w_sum[ID_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_id    = w_sum[ID_W-1:0];
            end
        end
    end

    assign w_last = (r_cnt == c_CNT_W'(HOLD_CYCLES - 1));

    always_ff @(posedge clock100KHz) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = '0;
        w_grant      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_win_found) begin
                    w_ready[w_win_id] = 1'b1;
                    w_grant           = 1'b1;
                    w_state_next      = c_WAIT;
                end
            end
            c_WAIT: begin
                if (w_last) begin
                    w_state_next = c_RESPOND;
                end
            end
            c_RESPOND: w_state_next = c_IDLE;
            default:   w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clock100KHz) begin
        if (!reset) begin
            r_ptr        <= '0;
            r_id         <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_data   <= '0;
            r_rsp_status <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_grant) begin
                r_op_a <= req_op_a[{w_win_id, 5'b0} +: 32];
                r_op_b <= req_op_b[{w_win_id, 5'b0} +: 32];
                r_id   <= w_win_id;
                r_ptr  <= (w_win_id == ID_W'(N_REQ - 1)) ? '0 : w_win_id + ID_W'(1);
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end
            // The FPU has no handshake, so the result is taken on the final hold cycle.
            if (r_state == c_WAIT) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
                if (w_last) begin
                    r_rsp_data   <= fpu_data_in;
                    r_rsp_status <= fpu_status_in;
                    r_rsp_id     <= r_id;
                    r_rsp_valid  <= 1'b1;
                end
            end
            if (r_state == c_RESPOND) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign req_ready  = w_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign rsp_status = r_rsp_status;
    assign busy       = r_busy;
    assign fpu_op_a   = r_op_a;
    assign fpu_op_b   = r_op_b;

endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_arbiter
// Purpose  : Directed and randomized checks of fpu_arbiter against a
//            transaction-level model, with a stand-in FPU behind it.
// Revision : 1.0  initial release
// ============================================================================
module tb_fpu_arbiter;

    localparam int N_REQ = 4;
    localparam int HOLD  = 256;
    localparam int ID_W  = 2;

    logic                clock100KHz = 1'b0;
    logic                reset       = 1'b0;
    logic [N_REQ-1:0]    req_valid   = '0;
    logic [32*N_REQ-1:0] req_op_a    = '0;
    logic [32*N_REQ-1:0] req_op_b    = '0;
    logic [N_REQ-1:0]    req_ready;
    logic                rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [31:0]         rsp_data;
    logic [3:0]          rsp_status;
    logic                busy;
    logic [31:0]         fpu_op_a;
    logic [31:0]         fpu_op_b;
    logic [31:0]         fpu_data_in;
    logic [3:0]          fpu_status_in;

    fpu_arbiter #(.N_REQ(N_REQ), .HOLD_CYCLES(HOLD)) dut (
        .clock100KHz   (clock100KHz),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_op_a      (req_op_a),
        .req_op_b      (req_op_b),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_status    (rsp_status),
        .busy          (busy),
        .fpu_op_a      (fpu_op_a),
        .fpu_op_b      (fpu_op_b),
        .fpu_data_in   (fpu_data_in),
        .fpu_status_in (fpu_status_in)
    );

    always #5 clock100KHz = ~clock100KHz;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Stand-in FPU: exact for doubling and cancellation, arbitrary mixing otherwise.
    function automatic logic [31:0] fpu_add(logic [31:0] a, logic [31:0] b);
        if (a == b && a[30:25] != 6'h3F) return {a[31], a[30:25] + 6'd1, a[24:0]};
        if (a == b) return {a[31], 6'h3F, 25'h0};
        if (a == {~b[31], b[30:0]}) return 32'h0;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    function automatic logic [3:0] fpu_stat(logic [31:0] a, logic [31:0] b);
        if (a == b && a[30:25] == 6'h3F) return 4'b0100;
        if (a == b || a == {~b[31], b[30:0]}) return 4'b0001;
        return 4'b0001 << (a[1:0] ^ b[1:0]);
    endfunction

    // The stand-in output is garbage until the operands have been stable long enough.
    logic [31:0] stub_a   = '0;
    logic [31:0] stub_b   = '0;
    int          stub_age = 0;
    always @(posedge clock100KHz) begin
        cyc <= cyc + 1;
        if (fpu_op_a !== stub_a || fpu_op_b !== stub_b) begin
            stub_a   <= fpu_op_a;
            stub_b   <= fpu_op_b;
            stub_age <= 0;
        end else if (stub_age < 1000) begin
            stub_age <= stub_age + 1;
        end
    end
    assign fpu_data_in   = (stub_age >= 68)  ? fpu_add(stub_a, stub_b)  : 32'hDEAD_BEEF;
    assign fpu_status_in = (stub_age >= 136) ? fpu_stat(stub_a, stub_b) : 4'b0000;

    // Transaction model: m_age counts cycles since the grant edge.
    bit          m_known  = 1'b0;
    bit          m_active = 1'b0;
    int          m_age    = 0;
    int          m_ptr    = 0;
    int          m_id     = 0;
    int          m_rid    = 0;
    logic [31:0] m_fa = '0, m_fb = '0, m_rd = '0;
    logic [3:0]  m_rs = '0;

    int          g_cyc[$], g_id[$], r_cyc[$], r_id[$];
    logic [31:0] r_data[$];
    logic [3:0]  r_stat[$];

    always @(negedge clock100KHz) begin : compare
        logic [N_REQ-1:0] exp_ready;
        int w;
        exp_ready = '0;
        w = -1;
        if (!m_active) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
            end
            if (w >= 0) exp_ready[w] = 1'b1;
        end
        if (m_known) begin
            chk("req_ready",  req_ready,  exp_ready);
            chk("busy",       busy,       m_active);
            chk("rsp_valid",  rsp_valid,  m_active && m_age == HOLD + 1);
            chk("rsp_id",     rsp_id,     m_rid);
            chk("rsp_data",   rsp_data,   m_rd);
            chk("rsp_status", rsp_status, m_rs);
            chk("fpu_op_a",   fpu_op_a,   m_fa);
            chk("fpu_op_b",   fpu_op_b,   m_fb);
            if (reset && rsp_valid) begin
                r_cyc.push_back(cyc);
                r_id.push_back(int'(rsp_id));
                r_data.push_back(rsp_data);
                r_stat.push_back(rsp_status);
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (reset && req_ready[i]) begin
                    g_cyc.push_back(cyc);
                    g_id.push_back(i);
                end
            end
        end
        if (!reset) begin
            m_known = 1'b1; m_active = 1'b0; m_age = 0; m_ptr = 0; m_rid = 0;
            m_fa = '0; m_fb = '0; m_rd = '0; m_rs = '0;
        end else if (m_known) begin
            if (m_active) begin
                if (m_age == HOLD + 1) begin
                    m_active = 1'b0;
                end else begin
                    if (m_age == HOLD) begin
                        m_rd  = fpu_add(m_fa, m_fb);
                        m_rs  = fpu_stat(m_fa, m_fb);
                        m_rid = m_id;
                    end
                    m_age++;
                end
            end else if (w >= 0) begin
                m_active = 1'b1;
                m_age    = 1;
                m_id     = w;
                m_fa     = req_op_a[32*w +: 32];
                m_fb     = req_op_b[32*w +: 32];
                m_ptr    = (w + 1) % N_REQ;
            end
        end
    end

    task automatic tick();
        @(posedge clock100KHz);
        #1;
    endtask

    task automatic clear_log();
        g_cyc.delete(); g_id.delete(); r_cyc.delete(); r_id.delete();
        r_data.delete(); r_stat.delete();
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_op_a[32*i +: 32] = a;
        req_op_b[32*i +: 32] = b;
    endtask

    task automatic rand_ops(input int i);
        logic [31:0] a;
        int kind;
        a    = $urandom;
        kind = $urandom_range(0, 2);
        set_ops(i, a, (kind == 0) ? a : (kind == 1) ? {~a[31], a[30:0]} : 32'($urandom));
    endtask

    task automatic wait_grant(input int id, input int budget);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clock100KHz);
            if (reset && req_ready[id]) seen = 1'b1;
            else n++;
        end
        chk($sformatf("grant_%0d_in_time", id), seen, 1);
        tick();
    endtask

    task automatic wait_rsp(input int budget);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clock100KHz);
            if (rsp_valid) seen = 1'b1;
            else n++;
        end
        chk("rsp_in_time", seen, 1);
        tick();
    endtask

    initial begin : stim
        logic [N_REQ-1:0] pend;
        logic [N_REQ-1:0] got;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Doubling through requester 0.
        clear_log();
        set_ops(0, 32'h4000_0000, 32'h4000_0000);
        req_valid = 4'b0001;
        wait_grant(0, 10);
        req_valid = '0;
        wait_rsp(300);
        chk("t1_nrsp", r_cyc.size(), 1);
        if (r_cyc.size() > 0 && g_cyc.size() > 0) begin
            chk("t1_latency", r_cyc[0] - g_cyc[0], 257);
            chk("t1_id",      r_id[0],   0);
            chk("t1_data",    r_data[0], 32'h4200_0000);
            chk("t1_status",  r_stat[0], 4'b0001);
        end

        // Cancellation through requester 2.
        clear_log();
        set_ops(2, 32'h4000_0000, 32'hC000_0000);
        req_valid = 4'b0100;
        wait_grant(2, 10);
        req_valid = '0;
        wait_rsp(300);
        chk("t2_nrsp", r_cyc.size(), 1);
        if (r_cyc.size() > 0) begin
            chk("t2_id",     r_id[0],   2);
            chk("t2_data",   r_data[0], 32'h0);
            chk("t2_status", r_stat[0], 4'b0001);
        end

        // Serve requester 1 so the pointer sits at 2, then race 1 against 3.
        rand_ops(1);
        req_valid = 4'b0010;
        wait_grant(1, 10);
        req_valid = '0;
        wait_rsp(300);
        clear_log();
        rand_ops(1);
        rand_ops(3);
        req_valid = 4'b1010;
        wait_grant(3, 10);
        req_valid[3] = 1'b0;
        for (int c = 0; c < 50; c++) begin
            req_valid[1] = 1'($urandom_range(0, 1));
            @(negedge clock100KHz);
            chk("t6_no_ready", req_ready, 0);
            chk("t6_busy", busy, 1);
            tick();
        end
        req_valid[1] = 1'b1;
        wait_grant(1, 400);
        req_valid = '0;
        wait_rsp(300);
        chk("t4_ngrant", g_id.size(), 2);
        if (g_id.size() >= 2) begin
            chk("t4_first",  g_id[0], 3);
            chk("t4_second", g_id[1], 1);
            chk("t4_gap",    g_cyc[1] - g_cyc[0], 258);
        end

        // All requesters pending straight out of reset.
        reset = 1'b0;
        for (int i = 0; i < N_REQ; i++) rand_ops(i);
        req_valid = 4'b1111;
        tick();
        tick();
        clear_log();
        reset = 1'b1;
        for (int n = 0; n < 1400 && g_id.size() < 5; n++) tick();
        req_valid = '0;
        chk("t3_ngrant", g_id.size(), 5);
        if (g_id.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk($sformatf("t3_order_%0d", k), g_id[k], k % N_REQ);
            for (int k = 1; k < 5; k++) chk($sformatf("t3_gap_%0d", k), g_cyc[k] - g_cyc[k-1], 258);
        end
        wait_rsp(300);

        // Reset in the middle of a transaction.
        rand_ops(0);
        req_valid = 4'b0001;
        wait_grant(0, 10);
        req_valid = '0;
        repeat (98) tick();
        clear_log();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clock100KHz);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_busy",      busy,      0);
        chk("t5_rsp_data",  rsp_data,  0);
        chk("t5_fpu_op_a",  fpu_op_a,  0);
        tick();
        repeat (300) tick();
        chk("t5_no_rsp", r_cyc.size(), 0);
        clear_log();
        rand_ops(0);
        rand_ops(3);
        req_valid = 4'b1001;
        wait_grant(0, 10);
        req_valid[0] = 1'b0;
        wait_grant(3, 400);
        req_valid = '0;
        wait_rsp(300);
        chk("t5_ptr_first", (g_id.size() > 0) ? g_id[0] : -1, 0);

        // Randomized traffic with occasional resets.
        pend = '0;
        for (int c = 0; c < 12000; c++) begin
            @(negedge clock100KHz);
            got = reset ? req_ready : '0;
            @(posedge clock100KHz);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (got[i]) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 99) < 2) begin
                    pend[i] = 1'b1;
                    rand_ops(i);
                end
            end
            reset     = ($urandom_range(0, 3999) == 0) ? 1'b0 : 1'b1;
            req_valid = pend;
        end
        reset     = 1'b1;
        req_valid = '0;
        repeat (300) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d of %0d passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
